// File: rtl/dff_pkg.sv
// Shared limits and helpers for the dff_pipe_r register pipeline.
package dff_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 16;

    // Bits needed to count 0..depth occupied stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline slot: valid flag plus data register with clear/load/drop/hold.
module dff_pipe_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             drop,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    // Slot state: clear wins, then load, then drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid_r <= 1'b0;
            data_r  <= RST_VAL;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= din;
        end else if (drop) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/dff_pipe_r.sv
// Elastic register pipeline with a combinational ready chain (no bubbles).
// Optional occupancy port enabled by defining DFF_PIPE_R_OCC_EN.
module dff_pipe_r
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef DFF_PIPE_R_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occ
`endif
);

    logic             clear_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [DEPTH:0]   free_s;
    logic [DEPTH-1:0] xfer_s;
    logic [DEPTH-1:0] load_s;
    logic [DEPTH-1:0] v_s;
    logic [WIDTH-1:0] d_s   [DEPTH];
    logic [WIDTH-1:0] din_s [DEPTH];

    // Ready chain walks from the output back to stage 0 so a full pipe can
    // shift and accept in the same cycle.
    always_comb begin
        free_s     = {(DEPTH+1){1'b0}};
        xfer_s     = {DEPTH{1'b0}};
        load_s     = {DEPTH{1'b0}};
        free_s[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            xfer_s[i] = v_s[i] & free_s[i+1];
            free_s[i] = ~v_s[i] | xfer_s[i];
        end
        clear_s    = reset | flush;
        in_ready_s = free_s[0] & ~flush & ~reset;
        accept_s   = in_valid & in_ready_s;
        load_s[0]  = accept_s;
        din_s[0]   = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            load_s[i] = xfer_s[i-1];
            din_s[i]  = d_s[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        dff_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk   (clk),
            .clear (clear_s),
            .load  (load_s[g]),
            .drop  (xfer_s[g]),
            .din   (din_s[g]),
            .valid (v_s[g]),
            .data  (d_s[g])
        );
    end

    assign in_ready  = in_ready_s;
    assign out_valid = v_s[DEPTH-1];
    assign out_data  = d_s[DEPTH-1];

`ifdef DFF_PIPE_R_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] occ_r;

    // Occupancy: +1 on accept, -1 on output transfer, cleared with the stages.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            occ_r <= {OCC_W{1'b0}};
        end else if (accept_s && !xfer_s[DEPTH-1]) begin
            occ_r <= occ_r + OCC_W'(1'b1);
        end else if (!accept_s && xfer_s[DEPTH-1]) begin
            occ_r <= occ_r - OCC_W'(1'b1);
        end else begin
            occ_r <= occ_r;
        end
    end

    assign occ = occ_r;
`endif

endmodule
